// File: rtl/ps2_kbd_rx_fifo_if.sv
// Key-event output channel of the PS/2 receiver: a valid/ready handshake
// that carries the scancode together with its extended and release flags.
interface ps2_kbd_rx_fifo_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_rel;

    modport master (output evt_valid, evt_code, evt_ext, evt_rel, input evt_ready);
    modport slave  (input evt_valid, evt_code, evt_ext, evt_rel, output evt_ready);
endinterface

// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver. The pins are synchronised and the clock is
// deglitched. Frames are checked for start, parity and stop bits. The E0
// and F0 prefixes are folded into flags on the following scancode, and the
// resulting key events are queued in a small FIFO.
module ps2_kbd_rx_fifo #(
    parameter int FREQ_KHZ     = 25000,
    parameter int PS2_FREQ_KHZ = 10,
    parameter int TIMEOUT      = FREQ_KHZ / PS2_FREQ_KHZ,
    parameter int FILTER       = 4,
    parameter int DEPTH        = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    ps2_kbd_rx_fifo_if.master          evt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overflow,
    input  logic                       err_clr
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int FCW = $clog2(FILTER + 1);

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evt_t;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [3:0]     bcnt_q, bcnt_d;
    logic [10:0]    sr_q, sr_d;
    logic           chk_q, chk_d;
    logic           ext_q, ext_d, rel_q, rel_d;
    logic           pend_vld_q, pend_vld_d;
    evt_t           pend_q, pend_d;
    logic           ferr_q, ferr_d, ovf_q, ovf_d;
    evt_t           mem_q [DEPTH];
    evt_t           mem_d [DEPTH];
    logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic fall, toggle, abort, ferr_set;
    logic pop, push, drop, full;

    // Deglitch: the filtered level follows the synced clock only after
    // FILTER consecutive samples that disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (clk_s2_q == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCW'(FILTER - 1)) begin
            filt_d = clk_s2_q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
        fall   = filt_q & ~filt_d;
        toggle = filt_q ^ filt_d;
    end

    // Bit collection and the inactivity timer. A stale partial frame is
    // dropped in preference to taking a late edge into it.
    always_comb begin
        sr_d   = sr_q;
        bcnt_d = bcnt_q;
        chk_d  = 1'b0;
        if (toggle)
            tmr_d = '0;
        else if (tmr_q == TW'(TIMEOUT))
            tmr_d = tmr_q;
        else
            tmr_d = tmr_q + 1'b1;
        abort = (tmr_q == TW'(TIMEOUT)) && (bcnt_q != 4'd0);
        if (abort) begin
            bcnt_d = 4'd0;
        end else if (fall) begin
            sr_d = {dat_s2_q, sr_q[10:1]};
            if (bcnt_q == 4'd10) begin
                bcnt_d = 4'd0;
                chk_d  = 1'b1;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    // Frame check and prefix decode. Only plain scancodes produce an event.
    always_comb begin
        ext_d      = ext_q;
        rel_d      = rel_q;
        pend_vld_d = 1'b0;
        pend_d     = pend_q;
        ferr_set   = 1'b0;
        if (chk_q) begin
            if (sr_q[0] || !sr_q[10] || !(^sr_q[9:1])) begin
                ferr_set = 1'b1;
                ext_d    = 1'b0;
                rel_d    = 1'b0;
            end else if (sr_q[8:1] == 8'hE0) begin
                ext_d = 1'b1;
            end else if (sr_q[8:1] == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_d     = {ext_q, rel_q, sr_q[8:1]};
                ext_d      = 1'b0;
                rel_d      = 1'b0;
            end
        end
        if (abort) begin
            ferr_set = 1'b1;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
        end
        ferr_d = err_clr ? 1'b0 : ferr_q;
        if (ferr_set)
            ferr_d = 1'b1;
    end

    // Event FIFO. A push into a full FIFO is accepted only when the head
    // leaves in the same cycle; otherwise the event is dropped and flagged.
    always_comb begin
        full  = (cnt_q == CW'(DEPTH));
        pop   = (cnt_q != '0) && evt.evt_ready;
        push  = pend_vld_q && (!full || pop);
        drop  = pend_vld_q && full && !pop;
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wp_q] = pend_q;
            wp_d        = wp_q + 1'b1;
        end
        if (pop)
            rp_d = rp_q + 1'b1;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
        ovf_d = err_clr ? 1'b0 : ovf_q;
        if (drop)
            ovf_d = 1'b1;
    end

    // All state registers, with a synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            tmr_q      <= '0;
            bcnt_q     <= '0;
            sr_q       <= '0;
            chk_q      <= 1'b0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            tmr_q      <= tmr_d;
            bcnt_q     <= bcnt_d;
            sr_q       <= sr_d;
            chk_q      <= chk_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign evt.evt_valid = (cnt_q != '0);
    assign evt.evt_code  = mem_q[rp_q].code;
    assign evt.evt_ext   = mem_q[rp_q].ext;
    assign evt.evt_rel   = mem_q[rp_q].rel;
    assign fifo_count    = cnt_q;
    assign busy          = (bcnt_q != 4'd0);
    assign frame_err     = ferr_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Bench for the PS/2 receiver. Keyboard frames are driven bit by bit, and
// the resulting events are compared against a byte-level model of prefix
// decoding and queueing.
module tb_ps2_kbd_rx_fifo;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 2500;
    localparam int FILTER  = 4;
    localparam int HALF    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       err_clr = 1'b0;
    logic [3:0] fifo_count;
    logic       busy, frame_err, overflow;

    ps2_kbd_rx_fifo_if eif();

    ps2_kbd_rx_fifo #(
        .FREQ_KHZ(25000), .PS2_FREQ_KHZ(10), .TIMEOUT(TIMEOUT),
        .FILTER(FILTER), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt(eif), .fifo_count(fifo_count), .busy(busy),
        .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miscmp = 0;

    // Reference model: an event is {ext, rel, code}.
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic       m_ext = 1'b0, m_rel = 1'b0, m_err = 1'b0, m_ovf = 1'b0;

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic badp);
        logic par;
        par = ~(^b) ^ badp;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            wclk(HALF);
            ps2_clk = 1'b0;
            wclk(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic badp);
        if (badp) begin
            m_err = 1'b1; m_ext = 1'b0; m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_rel, b});
            else m_ovf = 1'b1;
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic badp);
        send_bits(mk(b, badp), 11);
        wclk(30);
        model_byte(b, badp);
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        wclk(1);
        err_clr = 1'b0;
        m_err = 1'b0; m_ovf = 1'b0;
    endtask

    // Collects every event the FIFO offers while ready is held high (bounded).
    task automatic drain();
        got_q.delete();
        @(negedge clk);
        eif.evt_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (!eif.evt_valid) break;
            got_q.push_back({eif.evt_ext, eif.evt_rel, eif.evt_code});
            @(negedge clk);
        end
        eif.evt_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wclk(4);
        @(negedge clk);
        vec++;
        if ({eif.evt_valid, eif.evt_code, eif.evt_ext, eif.evt_rel} !== 11'h0) begin
            miscmp++; $display("FAIL reset_head: got %h exp 0", {eif.evt_valid, eif.evt_code, eif.evt_ext, eif.evt_rel});
        end
        vec++;
        if ({fifo_count, busy, frame_err, overflow} !== 7'h0) begin
            miscmp++; $display("FAIL reset_status: got %h exp 0", {fifo_count, busy, frame_err, overflow});
        end
        rst_n = 1'b1;
        wclk(10);
    endtask

    task automatic test_single();
        clr_err();
        send_byte(8'h1C, 1'b0);
        vec++;
        if (fifo_count !== 4'd1) begin
            miscmp++; $display("FAIL single_count: got %0d exp 1", fifo_count);
        end
        drain();
        vec++;
        if (got_q.size() != exp_q.size() || got_q.size() != 1 || got_q[0] !== {2'b00, 8'h1C}) begin
            miscmp++; $display("FAIL single_evt: got %0d events first %h exp %h", got_q.size(), got_q.size() ? got_q[0] : 10'h0, {2'b00, 8'h1C});
        end
        vec++;
        if (frame_err !== 1'b0) begin
            miscmp++; $display("FAIL single_err: got %b exp 0", frame_err);
        end
        exp_q.delete();
    endtask

    task automatic test_prefix();
        clr_err();
        send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
        vec++;
        if (fifo_count !== 4'd2) begin
            miscmp++; $display("FAIL prefix_count: got %0d exp 2", fifo_count);
        end
        drain();
        vec++;
        if (got_q.size() != exp_q.size()) begin
            miscmp++; $display("FAIL prefix_n: got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (got_q[i] !== exp_q[i]) begin
                miscmp++; $display("FAIL prefix_evt%0d: got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_parity();
        clr_err();
        send_byte(8'h1C, 1'b1);
        vec++;
        if ({frame_err, fifo_count} !== {m_err, 4'd0}) begin
            miscmp++; $display("FAIL parity_err: got %h exp %h", {frame_err, fifo_count}, {m_err, 4'd0});
        end
        clr_err();
        vec++;
        if (frame_err !== 1'b0) begin
            miscmp++; $display("FAIL parity_clr: got %b exp 0", frame_err);
        end
        send_byte(8'h32, 1'b0);
        drain();
        vec++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            miscmp++; $display("FAIL parity_next: got %0d events first %h exp %h", got_q.size(), got_q.size() ? got_q[0] : 10'h0, exp_q[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        clr_err();
        send_bits(mk(8'h55, 1'b0), 5);
        wclk(10);
        vec++;
        if (busy !== 1'b1) begin
            miscmp++; $display("FAIL timeout_busy: got %b exp 1", busy);
        end
        wclk(TIMEOUT + 100);
        m_err = 1'b1; m_ext = 1'b0; m_rel = 1'b0;
        vec++;
        if ({busy, frame_err} !== {1'b0, m_err}) begin
            miscmp++; $display("FAIL timeout_abort: got %b exp %b", {busy, frame_err}, {1'b0, m_err});
        end
        send_byte(8'h4A, 1'b0);
        drain();
        vec++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            miscmp++; $display("FAIL timeout_next: got %0d events first %h exp %h", got_q.size(), got_q.size() ? got_q[0] : 10'h0, exp_q[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_overflow();
        clr_err();
        for (int i = 1; i <= DEPTH + 1; i++) send_byte(8'(i), 1'b0);
        vec++;
        if ({fifo_count, overflow} !== {4'(DEPTH), m_ovf}) begin
            miscmp++; $display("FAIL ovf_status: got %h exp %h", {fifo_count, overflow}, {4'(DEPTH), m_ovf});
        end
        drain();
        vec++;
        if (got_q.size() != DEPTH) begin
            miscmp++; $display("FAIL ovf_n: got %0d exp %0d", got_q.size(), DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (got_q[i] !== {2'b00, 8'(i + 1)}) begin
                miscmp++; $display("FAIL ovf_evt%0d: got %h exp %h", i, got_q[i], {2'b00, 8'(i + 1)});
            end
        end
        exp_q.delete();
    endtask

    task automatic test_glitch();
        logic [10:0] fr;
        clr_err();
        ps2_clk = 1'b0; wclk(FILTER - 1); ps2_clk = 1'b1; wclk(20);
        vec++;
        if (busy !== 1'b0) begin
            miscmp++; $display("FAIL glitch_idle: got busy %b exp 0", busy);
        end
        fr = mk(8'h29, 1'b0);
        send_bits(fr, 3);
        ps2_clk = 1'b0; wclk(FILTER - 1); ps2_clk = 1'b1; wclk(HALF);
        send_bits(fr >> 3, 8);
        wclk(30);
        model_byte(8'h29, 1'b0);
        drain();
        vec++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || frame_err !== 1'b0) begin
            miscmp++; $display("FAIL glitch_frame: got %0d events first %h err %b exp %h", got_q.size(), got_q.size() ? got_q[0] : 10'h0, frame_err, exp_q[0]);
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       bad;
        for (int blk = 0; blk < 3; blk++) begin
            clr_err();
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 5))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    default: b = 8'($urandom);
                endcase
                bad = ($urandom_range(0, 7) == 0);
                send_byte(b, bad);
            end
            vec++;
            if ({frame_err, overflow, fifo_count} !== {m_err, m_ovf, 4'(exp_q.size())}) begin
                miscmp++; $display("FAIL rand_status%0d: got %h exp %h", blk, {frame_err, overflow, fifo_count}, {m_err, m_ovf, 4'(exp_q.size())});
            end
            drain();
            vec++;
            if (got_q.size() != exp_q.size()) begin
                miscmp++; $display("FAIL rand_n%0d: got %0d exp %0d", blk, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                vec++;
                if (got_q[i] !== exp_q[i]) begin
                    miscmp++; $display("FAIL rand_evt%0d_%0d: got %h exp %h", blk, i, got_q[i], exp_q[i]);
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        clr_err();
        send_byte(8'h2B, 1'b0);
        send_bits(mk(8'h66, 1'b0), 5);
        wclk(10);
        vec++;
        if ({busy, fifo_count} !== {1'b1, 4'd1}) begin
            miscmp++; $display("FAIL rstmid_pre: got %h exp %h", {busy, fifo_count}, {1'b1, 4'd1});
        end
        rst_n = 1'b0;
        wclk(1);
        @(negedge clk);
        vec++;
        if ({eif.evt_valid, eif.evt_code, eif.evt_ext, eif.evt_rel, fifo_count, busy, frame_err, overflow} !== 18'h0) begin
            miscmp++; $display("FAIL rstmid_outs: got %h exp 0", {eif.evt_valid, eif.evt_code, eif.evt_ext, eif.evt_rel, fifo_count, busy, frame_err, overflow});
        end
        rst_n = 1'b1;
        exp_q.delete(); m_ext = 1'b0; m_rel = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
        wclk(20);
        send_byte(8'h3C, 1'b0);
        drain();
        vec++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            miscmp++; $display("FAIL rstmid_next: got %0d events first %h exp %h", got_q.size(), got_q.size() ? got_q[0] : 10'h0, exp_q[0]);
        end
        exp_q.delete();
    endtask

    initial begin
        eif.evt_ready = 1'b0;
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_timeout();
        test_overflow();
        test_glitch();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
